// File: rtl/id_ex_control_pkg.sv
// Shared opcode and ALU control encodings, plus the per-opcode control decode
// used by the ID/EX stage and the ALU control decoder.
package id_ex_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_ADDU = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_LUI  = 4'b1110;
  localparam logic [3:0] ALU_FUNC = 4'b1111;

  typedef struct packed {
    logic       legal;
    logic [3:0] aluop;
    logic       regdst;
    logic       alusrc;
    logic       signext;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
  } ctrl_t;

  // Unknown opcodes return all-zero controls with legal=0.
  function automatic ctrl_t decode(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    c.legal = 1'b1;
    case (op)
      OP_RTYPE: begin c.aluop = ALU_FUNC; c.regdst = 1'b1; c.regwrite = 1'b1; end
      OP_ADDI:  begin c.aluop = ALU_ADD;  c.alusrc = 1'b1; c.signext = 1'b1; c.regwrite = 1'b1; end
      OP_ADDIU: begin c.aluop = ALU_ADDU; c.alusrc = 1'b1; c.signext = 1'b1; c.regwrite = 1'b1; end
      OP_SLTI:  begin c.aluop = ALU_SLT;  c.alusrc = 1'b1; c.signext = 1'b1; c.regwrite = 1'b1; end
      OP_SLTIU: begin c.aluop = ALU_SLTU; c.alusrc = 1'b1; c.signext = 1'b1; c.regwrite = 1'b1; end
      OP_ANDI:  begin c.aluop = ALU_AND;  c.alusrc = 1'b1; c.regwrite = 1'b1; end
      OP_ORI:   begin c.aluop = ALU_OR;   c.alusrc = 1'b1; c.regwrite = 1'b1; end
      OP_XORI:  begin c.aluop = ALU_XOR;  c.alusrc = 1'b1; c.regwrite = 1'b1; end
      OP_LUI:   begin c.aluop = ALU_LUI;  c.alusrc = 1'b1; c.regwrite = 1'b1; end
      OP_LW: begin
        c.aluop = ALU_ADD; c.alusrc = 1'b1; c.signext = 1'b1;
        c.memread = 1'b1; c.memtoreg = 1'b1; c.regwrite = 1'b1;
      end
      OP_SW:    begin c.aluop = ALU_ADD;  c.alusrc = 1'b1; c.signext = 1'b1; c.memwrite = 1'b1; end
      OP_BEQ:   begin c.aluop = ALU_SUB;  c.signext = 1'b1; end
      OP_J, OP_JAL: c.aluop = ALU_AND;
      default:  c.legal = 1'b0;
    endcase
    return c;
  endfunction

  // Opcodes whose rt field is a source operand rather than a destination.
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/id_ex_control_load_use_detect.sv
// Load-use hazard: the load in EX writes a register the ID instruction reads.
module load_use_detect
  import id_ex_control_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       uses_rt,
  input  logic       inst_valid,
  output logic       hazard
);

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign hazard = ex_valid && ex_memread && inst_valid && (ex_rt != 5'd0) &&
                  ((ex_rt == rs) || ((ex_rt == rt) && uses_rt));

endmodule

// File: rtl/id_ex_control.sv
// ID/EX pipeline register with control decode, load-use stall, flush and a
// sticky illegal-opcode flag.
module id_ex_control
  import id_ex_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] func_in,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  input  logic       inst_valid,
  input  logic       flush,
  output logic [3:0] ex_aluop,
  output logic [5:0] ex_funccode,
  output logic [4:0] ex_rs,
  output logic [4:0] ex_rt,
  output logic [4:0] ex_rd,
  output logic       ex_regdst,
  output logic       ex_alusrc,
  output logic       ex_signext,
  output logic       ex_memread,
  output logic       ex_memwrite,
  output logic       ex_memtoreg,
  output logic       ex_regwrite,
  output logic       ex_valid,
  output logic       stall,
  output logic       branch,
  output logic       jump,
  output logic       illegal_op
);

  // Handshake: inst_valid marks a real instruction in ID; stall holds it there
  // (it is re-presented and issues on the first edge with stall=0); ex_valid
  // marks a real instruction in EX, and every bubble has ex_valid=0.
  ctrl_t dec;
  logic  hazard;
  logic  issue;

  assign dec = decode(opcode);

  load_use_detect u_load_use_detect (
    .ex_valid   (ex_valid),
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .rs         (rs),
    .rt         (rt),
    .uses_rt    (uses_rt(opcode)),
    .inst_valid (inst_valid),
    .hazard     (hazard)
  );

  assign stall  = hazard && !flush;
  assign issue  = inst_valid && !flush && !stall;
  assign branch = issue && (opcode == OP_BEQ);
  assign jump   = issue && ((opcode == OP_J) || (opcode == OP_JAL));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_aluop    <= '0;
      ex_funccode <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_regdst   <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_signext  <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_valid    <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      if (issue && dec.legal) begin
        ex_aluop    <= dec.aluop;
        ex_funccode <= func_in;
        ex_rs       <= rs;
        ex_rt       <= rt;
        ex_rd       <= rd;
        ex_regdst   <= dec.regdst;
        ex_alusrc   <= dec.alusrc;
        ex_signext  <= dec.signext;
        ex_memread  <= dec.memread;
        ex_memwrite <= dec.memwrite;
        ex_memtoreg <= dec.memtoreg;
        ex_regwrite <= dec.regwrite;
        ex_valid    <= 1'b1;
      end else begin
        ex_aluop    <= '0;
        ex_funccode <= '0;
        ex_rs       <= '0;
        ex_rt       <= '0;
        ex_rd       <= '0;
        ex_regdst   <= 1'b0;
        ex_alusrc   <= 1'b0;
        ex_signext  <= 1'b0;
        ex_memread  <= 1'b0;
        ex_memwrite <= 1'b0;
        ex_memtoreg <= 1'b0;
        ex_regwrite <= 1'b0;
        ex_valid    <= 1'b0;
      end
      // A flushed instruction never executes, so it cannot raise the flag.
      if (issue && !dec.legal)
        illegal_op <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_control.sv
// Directed-vector bench for id_ex_control with an expected-response queue
// drained by a negedge monitor.
module tb_id_ex_control;

  localparam int W = 37;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] func_in = '0;
  logic [4:0] rs = '0;
  logic [4:0] rt = '0;
  logic [4:0] rd = '0;
  logic       inst_valid = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] ex_aluop;
  logic [5:0] ex_funccode;
  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic       ex_regdst, ex_alusrc, ex_signext, ex_memread, ex_memwrite;
  logic       ex_memtoreg, ex_regwrite, ex_valid;
  logic       stall, branch, jump, illegal_op;

  id_ex_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func_in(func_in),
    .rs(rs), .rt(rt), .rd(rd), .inst_valid(inst_valid), .flush(flush),
    .ex_aluop(ex_aluop), .ex_funccode(ex_funccode), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regdst(ex_regdst),
    .ex_alusrc(ex_alusrc), .ex_signext(ex_signext), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .ex_regwrite(ex_regwrite), .ex_valid(ex_valid), .stall(stall),
    .branch(branch), .jump(jump), .illegal_op(illegal_op)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [33:0]  pend_reg;
  logic         pend_valid = 1'b0;
  int           n_vectors = 0;
  int           n_fail = 0;

  // {aluop, func, rs, rt, rd, regdst..valid (8 bits), illegal}
  function automatic logic [33:0] ex(input logic [3:0] aluop, input logic [5:0] fn,
                                     input logic [4:0] a, input logic [4:0] b,
                                     input logic [4:0] d, input logic [7:0] ctrl,
                                     input logic ill);
    return {aluop, fn, a, b, d, ctrl, ill};
  endfunction

  function automatic logic [33:0] act_reg();
    return {ex_aluop, ex_funccode, ex_rs, ex_rt, ex_rd, ex_regdst, ex_alusrc,
            ex_signext, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite,
            ex_valid, illegal_op};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_vectors++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // driver tasks
  task automatic present(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] d, input logic iv,
                         input logic fl, input logic [2:0] exp_comb, input logic [33:0] exp_reg);
    opcode = op; func_in = fn; rs = a; rt = b; rd = d; inst_valid = iv; flush = fl;
    exp_q.push_back({exp_comb, exp_reg});
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] a,
                       input logic [4:0] b, input logic [4:0] d, input logic iv,
                       input logic fl, input logic [2:0] exp_comb, input logic [33:0] exp_reg);
    @(posedge clk);
    #1;
    present(op, fn, a, b, d, iv, fl, exp_comb, exp_reg);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    inst_valid = 1'b0;
    flush = 1'b0;
  endtask

  // monitor: registered result of the previous vector, then comb outputs of this one
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset) begin
      pend_valid = 1'b0;
    end else begin
      if (pend_valid)
        check("ex_regs", {3'b000, act_reg()}, {3'b000, pend_reg});
      pend_valid = 1'b0;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall_branch_jump", {34'd0, stall, branch, jump}, {34'd0, e[36:34]});
        pend_reg = e[33:0];
        pend_valid = 1'b1;
      end
    end
  end

  localparam logic [7:0] C_R   = 8'b1000_0011;
  localparam logic [7:0] C_IA  = 8'b0110_0011;
  localparam logic [7:0] C_IL  = 8'b0100_0011;
  localparam logic [7:0] C_LW  = 8'b0111_0111;
  localparam logic [7:0] C_SW  = 8'b0110_1001;
  localparam logic [7:0] C_BEQ = 8'b0010_0001;
  localparam logic [7:0] C_J   = 8'b0000_0001;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {stall, branch, jump, act_reg()}, '0);
    @(negedge clk);
    reset = 1'b0;

    drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 1, 0, 3'b000, ex(4'hF, 6'h20, 1, 2, 3, C_R, 0));   // ADD
    drive(6'h08, 6'h05, 5'd4, 5'd6, 5'd7, 1, 0, 3'b000, ex(4'h2, 6'h05, 4, 6, 7, C_IA, 0));  // ADDI
    drive(6'h0D, 6'h00, 5'd3, 5'd4, 5'd0, 1, 0, 3'b000, ex(4'h1, 6'h00, 3, 4, 0, C_IL, 0));  // ORI
    drive(6'h0F, 6'h00, 5'd0, 5'd9, 5'd0, 1, 0, 3'b000, ex(4'hE, 6'h00, 0, 9, 0, C_IL, 0));  // LUI
    drive(6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 1, 0, 3'b000, ex(4'h2, 6'h00, 1, 5, 0, C_LW, 0));  // LW r5
    drive(6'h00, 6'h20, 5'd5, 5'd2, 5'd8, 1, 0, 3'b100, ex(4'h0, 6'h00, 0, 0, 0, 8'h00, 0)); // stall
    drive(6'h00, 6'h20, 5'd5, 5'd2, 5'd8, 1, 0, 3'b000, ex(4'hF, 6'h20, 5, 2, 8, C_R, 0));   // reissue
    drive(6'h23, 6'h00, 5'd2, 5'd0, 5'd0, 1, 0, 3'b000, ex(4'h2, 6'h00, 2, 0, 0, C_LW, 0));  // LW r0
    drive(6'h00, 6'h20, 5'd0, 5'd3, 5'd4, 1, 0, 3'b000, ex(4'hF, 6'h20, 0, 3, 4, C_R, 0));   // no stall
    drive(6'h23, 6'h00, 5'd1, 5'd7, 5'd0, 1, 0, 3'b000, ex(4'h2, 6'h00, 1, 7, 0, C_LW, 0));  // LW r7
    drive(6'h08, 6'h00, 5'd9, 5'd7, 5'd0, 1, 0, 3'b000, ex(4'h2, 6'h00, 9, 7, 0, C_IA, 0));  // rt is dest
    drive(6'h23, 6'h00, 5'd1, 5'd7, 5'd0, 1, 0, 3'b000, ex(4'h2, 6'h00, 1, 7, 0, C_LW, 0));  // LW r7
    drive(6'h2B, 6'h00, 5'd2, 5'd7, 5'd0, 1, 0, 3'b100, ex(4'h0, 6'h00, 0, 0, 0, 8'h00, 0)); // SW stall
    drive(6'h2B, 6'h00, 5'd2, 5'd7, 5'd0, 1, 0, 3'b000, ex(4'h2, 6'h00, 2, 7, 0, C_SW, 0));  // SW
    drive(6'h23, 6'h00, 5'd1, 5'd9, 5'd0, 1, 0, 3'b000, ex(4'h2, 6'h00, 1, 9, 0, C_LW, 0));  // LW r9
    drive(6'h04, 6'h00, 5'd9, 5'd1, 5'd0, 1, 1, 3'b000, ex(4'h0, 6'h00, 0, 0, 0, 8'h00, 0)); // flush wins
    drive(6'h04, 6'h00, 5'd3, 5'd4, 5'd0, 1, 0, 3'b010, ex(4'h6, 6'h00, 3, 4, 0, C_BEQ, 0)); // BEQ
    drive(6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 1, 0, 3'b001, ex(4'h0, 6'h00, 0, 0, 0, C_J, 0));   // J
    drive(6'h04, 6'h00, 5'd3, 5'd4, 5'd0, 0, 0, 3'b000, ex(4'h0, 6'h00, 0, 0, 0, 8'h00, 0)); // invalid
    drive(6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 1, 0, 3'b000, ex(4'h2, 6'h00, 1, 5, 0, C_LW, 0));  // LW r5
    drive(6'h04, 6'h00, 5'd5, 5'd1, 5'd0, 1, 0, 3'b100, ex(4'h0, 6'h00, 0, 0, 0, 8'h00, 0)); // BEQ stall
    drive(6'h04, 6'h00, 5'd5, 5'd1, 5'd0, 1, 0, 3'b010, ex(4'h6, 6'h00, 5, 1, 0, C_BEQ, 0)); // BEQ
    drive(6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 1, 0, 3'b000, ex(4'h0, 6'h00, 0, 0, 0, 8'h00, 1)); // illegal
    drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 1, 0, 3'b000, ex(4'hF, 6'h20, 1, 2, 3, C_R, 1));   // sticky
    drive(6'h0B, 6'h00, 5'd4, 5'd5, 5'd0, 1, 0, 3'b000, ex(4'hB, 6'h00, 4, 5, 0, C_IA, 1));  // SLTIU
    drive(6'h0E, 6'h00, 5'd6, 5'd7, 5'd0, 1, 0, 3'b000, ex(4'hA, 6'h00, 6, 7, 0, C_IL, 1));  // XORI
    drive(6'h0C, 6'h00, 5'd1, 5'd2, 5'd0, 1, 0, 3'b000, ex(4'h0, 6'h00, 1, 2, 0, C_IL, 1));  // ANDI
    drive(6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 1, 0, 3'b001, ex(4'h0, 6'h00, 0, 0, 0, C_J, 1));   // JAL
    idle();

    // asynchronous reset while a load sits in EX and its consumer is stalled
    drive(6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 1, 0, 3'b000, ex(4'h2, 6'h00, 1, 5, 0, C_LW, 1));
    drive(6'h00, 6'h20, 5'd5, 5'd2, 5'd8, 1, 0, 3'b100, ex(4'h0, 6'h00, 0, 0, 0, 8'h00, 1));
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", {stall, branch, jump, act_reg()}, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    present(6'h00, 6'h20, 5'd5, 5'd2, 5'd8, 1, 0, 3'b000, ex(4'hF, 6'h20, 5, 2, 8, C_R, 0));
    idle();
    repeat (3) @(negedge clk);
    #1;

    n_vectors++;
    if (exp_q.size() != 0 || pend_valid) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, pending=%0d, required none", exp_q.size(), pend_valid);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_control.md
ID_EX_CONTROL -- requirements
Module: id_ex_control

Interface
REQ-001 SHALL have CLK input, 1 bit, the single clock; all state updates on rising edge.
REQ-002 SHALL have Reset input, 1 bit, asynchronous active-high; clears all state immediately.
REQ-003 SHALL have inputs Opcode 6, FuncIn 6, Rs 5, Rt 5, Rd 5 (ID-stage instruction fields), and InstValid 1 (ID instruction is real).
REQ-004 SHALL have input Flush, 1 bit: kill the ID-stage instruction (taken branch/jump).
REQ-005 SHALL have registered outputs EX_ALUOp 4, EX_FuncCode 6, EX_Rs 5, EX_Rt 5, EX_Rd 5, and 1-bit EX_RegDst, EX_ALUSrc, EX_SignExt, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_RegWrite, EX_Valid.
REQ-006 SHALL have combinational outputs Stall 1 (hold PC and IF/ID), Branch 1, Jump 1, and registered sticky IllegalOp 1.

Function
REQ-007 ALUOp encoding SHALL match the ALU control codes: R-type 000000 -> 1111; ADDI 001000 -> 0010; ADDIU 001001 -> 1000; SLTI 001010 -> 0111; SLTIU 001011 -> 1011; ANDI 001100 -> 0000; ORI 001101 -> 0001; XORI 001110 -> 1010; LUI 001111 -> 1110; LW 100011 and SW 101011 -> 0010; BEQ 000100 -> 0110; J 000010 and JAL 000011 -> 0000.
REQ-008 Decode: RegDst=1 R-type only; ALUSrc=1 all I-type except BEQ; SignExt=1 for ADDI, ADDIU, SLTI, SLTIU, LW, SW, BEQ; MemRead/MemToReg=1 LW; MemWrite=1 SW; RegWrite=1 R-type, arithmetic/logic I-type, LUI, LW.
REQ-009 Branch=1 for BEQ, Jump=1 for J/JAL, both only when InstValid=1 and Flush=0.
REQ-010 Opcode outside REQ-007 with InstValid=1 SHALL decode as bubble and set IllegalOp on the next edge; IllegalOp stays set until Reset.
REQ-011 Load-use hazard = EX_Valid & EX_MemRead & InstValid & EX_Rt!=0 & (EX_Rt==Rs | (EX_Rt==Rt & Opcode in {R-type, SW, BEQ})).
REQ-012 Stall SHALL equal hazard & ~Flush; when Stall=1, Branch and Jump SHALL be 0.
REQ-013 Per edge, priority: Flush, then Stall, then normal load.
REQ-014 Flush=1 or Stall=1 SHALL load a bubble: EX_Valid=0 and all 1-bit EX control outputs 0, EX_ALUOp=0000, fields 0.
REQ-015 Normal load SHALL capture decoded controls, FuncIn, Rs, Rt, Rd, with EX_Valid=InstValid; InstValid=0 loads a bubble.
REQ-016 Latency SHALL be exactly one cycle from ID inputs to EX outputs; stalled instruction re-presents in ID and issues the cycle after hazard clears.
REQ-017 Back-to-back LW then dependent use SHALL stall exactly one cycle (bubble clears EX_MemRead).

Reset
REQ-018 Reset SHALL force every registered output to 0, including EX_Valid and IllegalOp, asynchronously.
REQ-019 Reset mid-stall SHALL leave Stall=0 after release, since EX_Valid=0.
REQ-020 First edge after Reset deasserts SHALL perform a normal load.

Structure
REQ-021 Opcode constants and ALUOp codes SHALL reside in a shared package/include used by this block and the ALU control decoder.
REQ-022 Hazard logic SHALL be a sub-module load_use_detect (inputs EX_Valid, EX_MemRead, EX_Rt, Rs, Rt, UsesRt, InstValid; output hazard).

Verification
REQ-023 ADD R-type (Opcode 000000, FuncIn 100000, Rd=3), InstValid=1 -> next edge EX_ALUOp=1111, EX_FuncCode=100000, EX_RegDst=1, EX_RegWrite=1, EX_Valid=1.
REQ-024 LW Rt=5 then ADD Rs=5 -> Stall=1 one cycle, bubble (EX_Valid=0) in EX, ADD enters EX following edge.
REQ-025 LW Rt=0 then ADD Rs=0 -> Stall=0, no bubble.
REQ-026 Stall condition with Flush=1 -> Stall=0, Branch=0, bubble loaded.
REQ-027 Opcode 111111 InstValid=1 -> bubble, IllegalOp=1 held through later valid instructions until Reset.
REQ-028 Reset asserted between edges during valid LW in EX -> all EX outputs 0 immediately, no edge required.
